// File: rtl/breakout_pkg.sv
// breakout_pkg: shared definitions for the breakout game controller.
//   state_t      - game FSM encoding (3 bits; unused codes recover to NEWGAME)
//   TXT_*        - text overlay mode codes driven on text_mode
//   MAX_Y_TICK   - scan line on which the once-per-frame refresh tick fires
//   *_DEF        - default brick count and pause length
package breakout_pkg;

  typedef enum logic [2:0] {
    NEWGAME = 3'd0,
    PLAY    = 3'd1,
    NEWBALL = 3'd2,
    OVER    = 3'd3,
    WIN     = 3'd4
  } state_t;

  localparam logic [1:0] TXT_NONE  = 2'd0;
  localparam logic [1:0] TXT_START = 2'd1;
  localparam logic [1:0] TXT_OVER  = 2'd2;
  localparam logic [1:0] TXT_WIN   = 2'd3;

  localparam int MAX_Y_TICK     = 481;
  localparam int NUM_BRICKS_DEF = 48;
  localparam int WAIT_TICKS_DEF = 120;

endpackage

// File: rtl/breakout_bcd_cnt.sv
// breakout_bcd_cnt: two-digit BCD hit counter saturating at 99, with a
// parallel 6-bit binary count used for the brick-cleared compare.
//   clk, reset - clock, asynchronous active-high reset
//   clr        - synchronous clear (has priority over inc)
//   inc        - count one hit
//   d1, d0     - BCD tens / units digits
//   count      - binary hit count (saturates at 63)
module breakout_bcd_cnt
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [5:0] count
);

  logic at_max;
  assign at_max = (d1 == 4'd9) && (d0 == 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1    <= 4'd0;
      d0    <= 4'd0;
      count <= 6'd0;
    end else if (clr) begin
      d1    <= 4'd0;
      d0    <= 4'd0;
      count <= 6'd0;
    end else if (inc && !at_max) begin
      if (d0 == 4'd9) begin
        d0 <= 4'd0;
        d1 <= d1 + 4'd1;
      end else begin
        d0 <= d0 + 4'd1;
      end
      if (count != 6'd63) count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game sequencer for the breakout graphics datapath.
// Owns the game FSM, remaining balls, BCD score and the pause timer.
//   clk, reset      - clock, asynchronous active-high reset
//   btn             - player buttons, nonzero = press
//   pix_x, pix_y    - VGA scan position (used to derive the refresh tick)
//   hit, miss       - single-cycle events from the graphics block
//   gra_still       - freeze graphics in its initial position
//   score_d1/d0     - BCD score digits
//   balls           - balls remaining
//   text_mode       - overlay code (none / press-to-start / game over / win)
//   busy            - pause timer running
// Handshake: hit/miss/btn are plain level-sampled inputs; a hit or miss is
// consumed on every clock edge where it is high, there is no ready/ack.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int BALLS_INIT = 3,
  parameter int NUM_BRICKS = NUM_BRICKS_DEF,
  parameter int WAIT_TICKS = WAIT_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls,
  output logic [1:0] text_mode,
  output logic       busy
);

  localparam logic [6:0] TIMER_LOAD = 7'(WAIT_TICKS - 1);
  localparam logic [6:0] BRICKS     = 7'(NUM_BRICKS);
  localparam logic [1:0] BALLS_RST  = 2'(BALLS_INIT);

  state_t     state;
  logic [6:0] timer;
  logic [5:0] brick_cnt;
  logic       tick;
  logic       done;
  logic       press;
  logic       score_clr;
  logic       score_inc;
  logic       win_now;

  assign tick  = (pix_y == 10'(MAX_Y_TICK)) && (pix_x == 10'd0);
  assign done  = (timer == 7'd0);
  assign busy  = !done;
  assign press = (btn != 5'd0);

  // Score is cleared only when a new game starts, so final results stay up.
  assign score_clr = (state == NEWGAME) && press;
  assign score_inc = (state == PLAY) && hit;

  // The hit being scored this cycle counts toward the win, which is why the
  // compare looks at the incremented count rather than the registered one.
  assign win_now = score_inc && (({1'b0, brick_cnt} + 7'd1) == BRICKS);

  breakout_bcd_cnt u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (score_d1),
    .d0    (score_d0),
    .count (brick_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= NEWGAME;
      balls     <= BALLS_RST;
      timer     <= 7'd0;
      gra_still <= 1'b1;
      text_mode <= TXT_START;
    end else begin
      if (tick && !done) timer <= timer - 7'd1;
      case (state)
        NEWGAME: begin
          if (press) begin
            state     <= PLAY;
            balls     <= BALLS_RST;
            gra_still <= 1'b0;
            text_mode <= TXT_NONE;
          end
        end
        PLAY: begin
          if (win_now) begin
            state     <= WIN;
            timer     <= TIMER_LOAD;
            gra_still <= 1'b1;
            text_mode <= TXT_WIN;
          end else if (miss) begin
            timer     <= TIMER_LOAD;
            gra_still <= 1'b1;
            balls     <= balls - 2'd1;
            if (balls == 2'd1) begin
              state     <= OVER;
              text_mode <= TXT_OVER;
            end else begin
              state     <= NEWBALL;
              text_mode <= TXT_START;
            end
          end
        end
        NEWBALL: begin
          // A press during the pause is simply dropped, not remembered.
          if (done && press) begin
            state     <= PLAY;
            gra_still <= 1'b0;
            text_mode <= TXT_NONE;
          end
        end
        OVER, WIN: begin
          if (done) begin
            state     <= NEWGAME;
            gra_still <= 1'b1;
            text_mode <= TXT_START;
          end
        end
        default: begin
          state     <= NEWGAME;
          gra_still <= 1'b1;
          text_mode <= TXT_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_game_ctrl.sv
module tb_breakout_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = 5'd0;
  logic [9:0] pix_x = 10'd5;
  logic [9:0] pix_y = 10'd0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [3:0] score_d1, score_d0;
  logic [1:0] balls, text_mode;
  logic       busy;

  // second instance with an unreachable brick target, used for saturation
  logic [4:0] btn2 = 5'd0;
  logic       hit2 = 1'b0;
  logic       s_still;
  logic [3:0] s_d1, s_d0;
  logic [1:0] s_balls, s_text;
  logic       s_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  breakout_game_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
    .hit(hit), .miss(miss), .gra_still(gra_still), .score_d1(score_d1),
    .score_d0(score_d0), .balls(balls), .text_mode(text_mode), .busy(busy)
  );

  breakout_game_ctrl #(.NUM_BRICKS(100)) dut_sat (
    .clk(clk), .reset(reset), .btn(btn2), .pix_x(pix_x), .pix_y(pix_y),
    .hit(hit2), .miss(1'b0), .gra_still(s_still), .score_d1(s_d1),
    .score_d0(s_d0), .balls(s_balls), .text_mode(s_text), .busy(s_busy)
  );

  // ---- driver tasks ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn();
    btn = 5'h1;
    cyc();
    btn = 5'h0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      cyc();
    end
    hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pix_y = 10'd481;
      pix_x = 10'd0;
      cyc();
      pix_y = 10'd0;
      pix_x = 10'd5;
      cyc();
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_still", {7'd0, gra_still}, 8'd1);
    chk("rst_text", {6'd0, text_mode}, 8'd1);
    chk("rst_score", {score_d1, score_d0}, 8'h00);
    chk("rst_balls", {6'd0, balls}, 8'd3);
    chk("rst_busy", {7'd0, busy}, 8'd0);

    // start, 10 hits -> score 10
    press_btn();
    chk("play_still", {7'd0, gra_still}, 8'd0);
    chk("play_text", {6'd0, text_mode}, 8'd0);
    hits(10);
    chk("score10", {score_d1, score_d0}, 8'h10);
    hits(2);
    chk("score12", {score_d1, score_d0}, 8'h12);

    // reset mid-play
    reset = 1'b1;
    cyc();
    chk("mid_rst_still", {7'd0, gra_still}, 8'd1);
    chk("mid_rst_text", {6'd0, text_mode}, 8'd1);
    chk("mid_rst_score", {score_d1, score_d0}, 8'h00);
    chk("mid_rst_balls", {6'd0, balls}, 8'd3);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    reset = 1'b0;
    cyc();

    // miss with 3 balls -> NEWBALL
    press_btn();
    chk("play2_still", {7'd0, gra_still}, 8'd0);
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    chk("nb_text", {6'd0, text_mode}, 8'd1);
    chk("nb_still", {7'd0, gra_still}, 8'd1);
    chk("nb_balls", {6'd0, balls}, 8'd2);
    chk("nb_busy", {7'd0, busy}, 8'd1);
    hits(5);
    chk("nb_hit_ignored", {score_d1, score_d0}, 8'h00);
    ticks(50);
    press_btn();
    chk("nb_press_busy", {7'd0, gra_still}, 8'd1);
    ticks(68);
    chk("nb_busy_1left", {7'd0, busy}, 8'd1);
    ticks(1);
    chk("nb_done", {7'd0, busy}, 8'd0);
    chk("nb_wait_still", {7'd0, gra_still}, 8'd1);
    press_btn();
    chk("nb_resume", {7'd0, gra_still}, 8'd0);

    // down to last ball, then game over
    hits(3);
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    chk("nb2_balls", {6'd0, balls}, 8'd1);
    ticks(119);
    press_btn();
    chk("nb2_resume", {7'd0, gra_still}, 8'd0);
    miss = 1'b1;
    cyc();
    miss = 1'b0;
    chk("over_text", {6'd0, text_mode}, 8'd2);
    chk("over_balls", {6'd0, balls}, 8'd0);
    chk("over_busy", {7'd0, busy}, 8'd1);
    hits(4);
    chk("over_hit_ignored", {score_d1, score_d0}, 8'h03);
    ticks(118);
    chk("over_hold", {6'd0, text_mode}, 8'd2);
    ticks(1);
    chk("ng_text", {6'd0, text_mode}, 8'd1);
    chk("ng_score_held", {score_d1, score_d0}, 8'h03);
    chk("ng_balls_held", {6'd0, balls}, 8'd0);
    press_btn();
    chk("new_score", {score_d1, score_d0}, 8'h00);
    chk("new_balls", {6'd0, balls}, 8'd3);

    // win on simultaneous hit+miss
    hits(47);
    chk("score47", {score_d1, score_d0}, 8'h47);
    hit = 1'b1;
    miss = 1'b1;
    cyc();
    hit = 1'b0;
    miss = 1'b0;
    chk("win_text", {6'd0, text_mode}, 8'd3);
    chk("win_score", {score_d1, score_d0}, 8'h48);
    chk("win_balls", {6'd0, balls}, 8'd3);
    chk("win_still", {7'd0, gra_still}, 8'd1);
    ticks(119);
    chk("win_to_ng", {6'd0, text_mode}, 8'd1);
    chk("win_score_held", {score_d1, score_d0}, 8'h48);

    // saturation at 99 on the second instance
    btn2 = 5'h4;
    cyc();
    btn2 = 5'h0;
    chk("sat_play", {7'd0, s_still}, 8'd0);
    for (int i = 0; i < 99; i++) begin
      hit2 = 1'b1;
      cyc();
    end
    chk("sat_99", {s_d1, s_d0}, 8'h99);
    cyc();
    hit2 = 1'b0;
    chk("sat_hold", {s_d1, s_d0}, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
